// File: rtl/fetch_decode_buffer_if.sv
// ----------------------------------------------------------------------------
// fetch_decode_buffer_if
//  Fetch->decode bundle interface plus the decode-side handshake.
//  slave  : decode-side receiver (fetch_decode_buffer)
//  master : the fetch/ROB/decode environment that drives the receiver
//  Signals:
//   fetch_vld, pc_to_dec, inst_to_dec, recv_pc_to_dec, pred_result_to_dec
//                      incoming 4-wide bundle (slot i in bits [16i+15:16i])
//   has_mispredict     ROB flush request
//   dec_rdy            decode consumes head bundle
//   stall_fetch        back-pressure to fetch
//   dec_vld, dec_pc, dec_inst, dec_recv_pc, dec_pred
//                      head bundle presented to decode
//   ovf_err            sticky overflow flag
// ----------------------------------------------------------------------------
interface fetch_decode_buffer_if;
   logic        fetch_vld;
   logic [63:0] pc_to_dec;
   logic [63:0] inst_to_dec;
   logic [63:0] recv_pc_to_dec;
   logic [3:0]  pred_result_to_dec;
   logic        has_mispredict;
   logic        dec_rdy;
   logic        stall_fetch;
   logic        dec_vld;
   logic [63:0] dec_pc;
   logic [63:0] dec_inst;
   logic [63:0] dec_recv_pc;
   logic [3:0]  dec_pred;
   logic        ovf_err;

   modport slave (
      input  fetch_vld, pc_to_dec, inst_to_dec, recv_pc_to_dec,
             pred_result_to_dec, has_mispredict, dec_rdy,
      output stall_fetch, dec_vld, dec_pc, dec_inst, dec_recv_pc,
             dec_pred, ovf_err
   );

   modport master (
      output fetch_vld, pc_to_dec, inst_to_dec, recv_pc_to_dec,
             pred_result_to_dec, has_mispredict, dec_rdy,
      input  stall_fetch, dec_vld, dec_pc, dec_inst, dec_recv_pc,
             dec_pred, ovf_err
   );
endinterface

// File: rtl/fetch_decode_buffer.sv
// ----------------------------------------------------------------------------
// fetch_decode_buffer
//  Decode-side receiver of 4-wide fetch bundles. Buffers bundles in a
//  DEPTH-entry first-word-fall-through FIFO, presents the head to decode,
//  raises stall_fetch with SKID entries of slack, flushes on mispredict and
//  flags (sticky) any bundle dropped on a full buffer.
//  Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : fetch_decode_buffer_if.slave (bundle in, head bundle out,
//          stall_fetch, ovf_err)
// ----------------------------------------------------------------------------
module fetch_decode_buffer #(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 2,
   parameter int SKID   = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   fetch_decode_buffer_if.slave  bus
);

   typedef struct packed {
      logic [63:0] pc;
      logic [63:0] inst;
      logic [63:0] recv_pc;
      logic [3:0]  pred;
   } entry_t;

   localparam logic [ADDR_W:0]   FULL_LVL  = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0]   STALL_LVL = (ADDR_W+1)'(DEPTH - SKID);
   localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W+1)'(1);
   localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);

   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_W:0]   count_q,  count_d;
   logic              ovf_err_q, ovf_err_d;
   entry_t            mem_q [DEPTH];
   entry_t            mem_d [DEPTH];

   logic   full;
   logic   dec_vld;
   logic   push;
   logic   pop;
   logic   ovf;
   entry_t head;

   assign full    = (count_q == FULL_LVL);
   // Mispredict hides the head immediately so decode never consumes a
   // bundle that is being flushed.
   assign dec_vld = (count_q != '0) & ~bus.has_mispredict;
   assign pop     = bus.dec_rdy & dec_vld;
   assign push    = bus.fetch_vld & ~bus.has_mispredict & (~full | pop);
   assign ovf     = bus.fetch_vld & ~bus.has_mispredict & full & ~pop;
   assign head    = mem_q[rd_ptr_q];

   // Next-state for pointers, occupancy and the sticky overflow flag.
   always_comb begin
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      ovf_err_d = ovf_err_q | ovf;
      if (bus.has_mispredict) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
         if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
         if (push & ~pop)      count_d = count_q + CNT_ONE;
         else if (pop & ~push) count_d = count_q - CNT_ONE;
      end
   end

   // Bundle storage; contents are only ever observed through count_q.
   always_comb begin
      mem_d = mem_q;
      if (push) begin
         mem_d[wr_ptr_q].pc      = bus.pc_to_dec;
         mem_d[wr_ptr_q].inst    = bus.inst_to_dec;
         mem_d[wr_ptr_q].recv_pc = bus.recv_pc_to_dec;
         mem_d[wr_ptr_q].pred    = bus.pred_result_to_dec;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         ovf_err_q <= 1'b0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         ovf_err_q <= ovf_err_d;
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   // Head outputs are zeroed whenever nothing valid is presented.
   always_comb begin
      bus.dec_vld     = dec_vld;
      bus.dec_pc      = dec_vld ? head.pc      : '0;
      bus.dec_inst    = dec_vld ? head.inst    : '0;
      bus.dec_recv_pc = dec_vld ? head.recv_pc : '0;
      bus.dec_pred    = dec_vld ? head.pred    : '0;
      bus.stall_fetch = (count_q >= STALL_LVL);
      bus.ovf_err     = ovf_err_q;
   end

endmodule

// File: tb/tb_fetch_decode_buffer.sv
module tb_fetch_decode_buffer;

   typedef struct packed {
      logic [63:0] pc;
      logic [63:0] inst;
      logic [63:0] rpc;
      logic [3:0]  pred;
   } bundle_t;

   logic clk;
   logic rst;
   int   n_vec;
   int   n_err;
   bundle_t exp_q[$];
   bundle_t mon_e;
   bundle_t zb;

   fetch_decode_buffer_if bif();

   fetch_decode_buffer #(.DEPTH(4), .ADDR_W(2), .SKID(1)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Bundle k: pc slot s = 4k+s, inst slot s = A000+16k+s,
   // recovery slot s = 8000+4k+s, pred = (5k+1) mod 16.
   function automatic bundle_t mk(int k);
      bundle_t b;
      for (int s = 0; s < 4; s++) begin
         b.pc[16*s +: 16]   = 16'(4*k + s);
         b.inst[16*s +: 16] = 16'(32'hA000 + 16*k + s);
         b.rpc[16*s +: 16]  = 16'(32'h8000 + 4*k + s);
      end
      b.pred = 4'(5*k + 1);
      return b;
   endfunction

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic setin(logic fv, bundle_t b, logic mis, logic rdy);
      bif.fetch_vld          = fv;
      bif.pc_to_dec          = b.pc;
      bif.inst_to_dec        = b.inst;
      bif.recv_pc_to_dec     = b.rpc;
      bif.pred_result_to_dec = b.pred;
      bif.has_mispredict     = mis;
      bif.dec_rdy            = rdy;
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   // Monitor: every consumed head bundle must match the scoreboard front.
   always @(negedge clk) begin
      if (!rst && bif.dec_vld && bif.dec_rdy) begin
         if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_pop: got pc %h expected no bundle", bif.dec_pc);
         end else begin
            mon_e = exp_q.pop_front();
            chk("pop_pc",   bif.dec_pc,               mon_e.pc);
            chk("pop_inst", bif.dec_inst,             mon_e.inst);
            chk("pop_rpc",  bif.dec_recv_pc,          mon_e.rpc);
            chk("pop_pred", 64'(bif.dec_pred),        64'(mon_e.pred));
         end
      end
   end

   initial begin
      n_vec = 0;
      n_err = 0;
      zb    = '0;
      rst   = 1'b1;
      setin(1'b1, mk(99), 1'b0, 1'b0);

      // Reset held two cycles with fetch_vld high
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         chk("rst_dec_vld", 64'(bif.dec_vld), 64'd0);
         chk("rst_stall",   64'(bif.stall_fetch), 64'd0);
         chk("rst_dec_pc",  bif.dec_pc, 64'd0);
         chk("rst_ovf",     64'(bif.ovf_err), 64'd0);
         nxt();
      end
      rst = 1'b0;

      // Passthrough
      setin(1'b1, mk(0), 1'b0, 1'b1);
      exp_q.push_back(mk(0));
      @(negedge clk);
      chk("pt_empty_vld", 64'(bif.dec_vld), 64'd0);
      nxt();
      setin(1'b0, zb, 1'b0, 1'b1);
      @(negedge clk);
      chk("pt_vld", 64'(bif.dec_vld), 64'd1);
      chk("pt_pc",  bif.dec_pc, 64'h0003_0002_0001_0000);
      nxt();
      @(negedge clk);
      chk("pt_after_vld", 64'(bif.dec_vld), 64'd0);
      chk("pt_after_stall", 64'(bif.stall_fetch), 64'd0);
      nxt();

      // Fill to full, then overflow
      for (int k = 1; k <= 3; k++) begin
         setin(1'b1, mk(k), 1'b0, 1'b0);
         exp_q.push_back(mk(k));
         @(negedge clk);
         if (k == 3) chk("fill_stall_cnt2", 64'(bif.stall_fetch), 64'd0);
         nxt();
      end
      setin(1'b1, mk(4), 1'b0, 1'b0);
      exp_q.push_back(mk(4));
      @(negedge clk);
      chk("fill_stall_cnt3", 64'(bif.stall_fetch), 64'd1);
      chk("fill_head_pc", bif.dec_pc, mk(1).pc);
      nxt();
      setin(1'b1, mk(50), 1'b0, 1'b0);
      @(negedge clk);
      chk("full_ovf_before", 64'(bif.ovf_err), 64'd0);
      chk("full_stall", 64'(bif.stall_fetch), 64'd1);
      nxt();

      // Full with simultaneous pop: push accepted, head advances
      setin(1'b1, mk(5), 1'b0, 1'b1);
      exp_q.push_back(mk(5));
      @(negedge clk);
      chk("ovf_set", 64'(bif.ovf_err), 64'd1);
      chk("fullpop_head", bif.dec_pc, mk(1).pc);
      nxt();
      setin(1'b0, zb, 1'b0, 1'b1);
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chk("drain_stall", 64'(bif.stall_fetch), (c < 2) ? 64'd1 : 64'd0);
         nxt();
      end
      @(negedge clk);
      chk("drain_empty", 64'(bif.dec_vld), 64'd0);
      nxt();

      // Flush with three buffered bundles
      for (int k = 6; k <= 8; k++) begin
         setin(1'b1, mk(k), 1'b0, 1'b0);
         exp_q.push_back(mk(k));
         @(negedge clk);
         nxt();
      end
      setin(1'b1, mk(9), 1'b1, 1'b1);
      exp_q.delete();
      @(negedge clk);
      chk("flush_vld", 64'(bif.dec_vld), 64'd0);
      chk("flush_inst", bif.dec_inst, 64'd0);
      chk("flush_stall_during", 64'(bif.stall_fetch), 64'd1);
      nxt();
      setin(1'b0, zb, 1'b0, 1'b1);
      @(negedge clk);
      chk("post_flush_vld", 64'(bif.dec_vld), 64'd0);
      chk("post_flush_stall", 64'(bif.stall_fetch), 64'd0);
      chk("ovf_sticky", 64'(bif.ovf_err), 64'd1);
      nxt();

      // Asynchronous reset with bundles buffered
      for (int k = 20; k <= 21; k++) begin
         setin(1'b1, mk(k), 1'b0, 1'b0);
         @(negedge clk);
         nxt();
      end
      setin(1'b0, zb, 1'b0, 1'b0);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_vld", 64'(bif.dec_vld), 64'd0);
      chk("async_rst_ovf", 64'(bif.ovf_err), 64'd0);
      nxt();
      rst = 1'b0;

      // Wrap: 10 back-to-back push/pop pairs
      for (int i = 0; i < 10; i++) begin
         setin(1'b1, mk(30 + i), 1'b0, 1'b1);
         exp_q.push_back(mk(30 + i));
         @(negedge clk);
         if (i > 0) chk("wrap_vld", 64'(bif.dec_vld), 64'd1);
         nxt();
      end
      setin(1'b0, zb, 1'b0, 1'b1);
      @(negedge clk);
      nxt();
      @(negedge clk);
      chk("wrap_end_vld", 64'(bif.dec_vld), 64'd0);
      chk("wrap_ovf", 64'(bif.ovf_err), 64'd0);
      chk("sb_empty", 64'(exp_q.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
